seq_mult: RTL



---
 rtl/seq_mult_if.sv | 25 ++
 rtl/seq_mult.sv | 99 +++++++++
 2 files changed

// File: rtl/seq_mult_if.sv
// Operand/product handshake bundle for the digit-serial multiplier.
`timescale 1ns/1ps
interface seq_mult_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport master (
        output in_valid, in_signed, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, in_signed, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/seq_mult.sv
// Digit-serial WIDTH x WIDTH -> 2*WIDTH multiplier, DIGIT bits of b per cycle,
// signed operands handled as magnitudes with a sign fix-up on the final sum.
`timescale 1ns/1ps
module seq_mult #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input logic        clk,
    input logic        rst_n,
    seq_mult_if.slave  bus
);
    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_next;
    logic [PW-1:0]     mcand, mcand_next;
    logic [WIDTH-1:0]  mplier, mplier_next;
    logic              neg, neg_next;
    logic [PW-1:0]     acc, acc_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [PW-1:0]     p_next;
    logic [PW-1:0]     acc_sum;
    logic [WIDTH-1:0]  abs_a, abs_b;

    // Multiplicand is pre-shifted and the multiplier consumed from the bottom,
    // so each cycle only the low digit of mplier is needed.
    always_comb begin
        abs_a   = (bus.in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b   = (bus.in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        acc_sum = acc + mcand * PW'(mplier[DIGIT-1:0]);
    end

    always_comb begin
        state_next  = state;
        mcand_next  = mcand;
        mplier_next = mplier;
        neg_next    = neg;
        acc_next    = acc;
        cnt_next    = cnt;
        p_next      = bus.p;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_next  = PW'(abs_a);
                    mplier_next = abs_b;
                    neg_next    = bus.in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_next    = '0;
                    cnt_next    = '0;
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                acc_next    = acc_sum;
                mcand_next  = mcand << DIGIT;
                mplier_next = mplier >> DIGIT;
                cnt_next    = cnt + CNT_W'(1);
                if (cnt == LAST) begin
                    p_next     = neg ? -acc_sum : acc_sum;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags are flopped from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mcand         <= '0;
            mplier        <= '0;
            neg           <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            bus.p         <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_next;
            mcand         <= mcand_next;
            mplier        <= mplier_next;
            neg           <= neg_next;
            acc           <= acc_next;
            cnt           <= cnt_next;
            bus.p         <= p_next;
            bus.in_ready  <= (state_next == IDLE);
            bus.out_valid <= (state_next == DONE);
            bus.busy      <= (state_next != IDLE);
        end
    end
endmodule
